// File: rtl/mvm_stream_par.sv
`default_nettype none
// ============================================================================
// Module   : mvm_stream_par
// Purpose  : Streaming signed matrix-vector multiplier y = W*x on P parallel
//            saturating MAC lanes. W (MxN, row-major) then x (N) arrive on a
//            valid/ready input stream; y[0..M-1] leaves in row order on a
//            valid/ready output stream.
// Ports    : clk, reset (sync, active-high)
//            s_valid/s_ready/data_in     : element input stream
//            m_valid/m_ready/data_out    : result output stream
//            overflow                    : saturation flag for data_out
// Options  : MVM_VEC_REUSE_EN - when defined, x is loaded once after reset
//            and reused for every later W (LOAD_X is skipped).
// Revision : 1.0 - initial release
// ============================================================================
module mvm_stream_par #(
    parameter int M          = 4,
    parameter int N          = 4,
    parameter int P          = 2,
    parameter int IN_W       = 8,
    parameter int OUT_W      = 16,
    parameter int MAC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [IN_W-1:0]  data_in,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [OUT_W-1:0] data_out,
    output logic                    overflow
);

    localparam int c_GRPS  = M / P;
    localparam int c_DEPTH = c_GRPS * N;
    localparam int c_AW    = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
    localparam int c_NW    = $clog2(N);
    localparam int c_LW    = (P > 1) ? $clog2(P) : 1;
    localparam int c_GW    = (c_GRPS > 1) ? $clog2(c_GRPS) : 1;
    localparam int c_CW    = $clog2(N + MAC_STAGES + 2);

    localparam logic [1:0] c_LOAD_W  = 2'd0;
    localparam logic [1:0] c_LOAD_X  = 2'd1;
    localparam logic [1:0] c_COMPUTE = 2'd2;
    localparam logic [1:0] c_DRAIN   = 2'd3;

    localparam logic [c_NW-1:0] c_COL_LAST  = c_NW'(N - 1);
    localparam logic [c_LW-1:0] c_LANE_LAST = c_LW'(P - 1);
    localparam logic [c_GW-1:0] c_GRP_LAST  = c_GW'(c_GRPS - 1);
    // Reads are issued for r_cyc 0..N-1; the last product lands in the
    // accumulator at r_cyc N+MAC_STAGES, so the group is complete one
    // cycle later.
    localparam logic [c_CW-1:0] c_CYC_ISSUE = c_CW'(N);
    localparam logic [c_CW-1:0] c_CYC_LAST  = c_CW'(N + MAC_STAGES + 1);

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [c_NW-1:0] r_col;
    logic [c_LW-1:0] r_lane;   // load lane during LOAD_W, output row index in DRAIN
    logic [c_GW-1:0] r_grp;    // load group during LOAD_W, row group in COMPUTE/DRAIN
    logic [c_CW-1:0] r_cyc;

    logic w_s_hs, w_m_hs, w_w_last, w_x_last, w_skip_x;
    logic w_issue, w_grp_start;
    logic [c_NW-1:0] w_rcol;
    logic [c_AW-1:0] w_raddr, w_waddr;

    logic signed [IN_W-1:0]  r_x [N];
    logic signed [IN_W-1:0]  r_xd;
    logic [MAC_STAGES:0]     r_vld;
    logic signed [OUT_W-1:0] w_acc_all [P];
    logic                    w_ovf_all [P];

    assign w_s_hs   = s_valid && s_ready;
    assign w_m_hs   = m_valid && m_ready;
    assign w_w_last = (r_col == c_COL_LAST) && (r_lane == c_LANE_LAST) && (r_grp == c_GRP_LAST);
    assign w_x_last = (r_col == c_COL_LAST);

`ifdef MVM_VEC_REUSE_EN
    logic r_xvalid;
    always_ff @(posedge clk) begin
        if (reset)
            r_xvalid <= 1'b0;
        else if (r_state == c_LOAD_X && w_s_hs && w_x_last)
            r_xvalid <= 1'b1;
    end
    assign w_skip_x = r_xvalid;
`else
    assign w_skip_x = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= c_LOAD_W;
        else
            r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_LOAD_W:  if (w_s_hs && w_w_last) w_next = w_skip_x ? c_COMPUTE : c_LOAD_X;
            c_LOAD_X:  if (w_s_hs && w_x_last) w_next = c_COMPUTE;
            c_COMPUTE: if (r_cyc == c_CYC_LAST) w_next = c_DRAIN;
            c_DRAIN:   if (w_m_hs && r_lane == c_LANE_LAST)
                           w_next = (r_grp == c_GRP_LAST) ? c_LOAD_W : c_COMPUTE;
            default:   w_next = c_LOAD_W;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        s_ready = (r_state == c_LOAD_W) || (r_state == c_LOAD_X);
        m_valid = (r_state == c_DRAIN);
    end

    // ---------------- counters ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col  <= '0;
            r_lane <= '0;
            r_grp  <= '0;
            r_cyc  <= '0;
        end else begin
            case (r_state)
                c_LOAD_W: if (w_s_hs) begin
                    if (r_col == c_COL_LAST) begin
                        r_col <= '0;
                        if (r_lane == c_LANE_LAST) begin
                            r_lane <= '0;
                            r_grp  <= (r_grp == c_GRP_LAST) ? '0 : r_grp + c_GW'(1);
                        end else begin
                            r_lane <= r_lane + c_LW'(1);
                        end
                    end else begin
                        r_col <= r_col + c_NW'(1);
                    end
                end
                c_LOAD_X: if (w_s_hs)
                    r_col <= w_x_last ? '0 : r_col + c_NW'(1);
                c_COMPUTE:
                    r_cyc <= (r_cyc == c_CYC_LAST) ? '0 : r_cyc + c_CW'(1);
                c_DRAIN: if (w_m_hs) begin
                    if (r_lane == c_LANE_LAST) begin
                        r_lane <= '0;
                        r_grp  <= (r_grp == c_GRP_LAST) ? '0 : r_grp + c_GW'(1);
                    end else begin
                        r_lane <= r_lane + c_LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- x register file and read issue ----------------
    assign w_issue     = (r_state == c_COMPUTE) && (r_cyc < c_CYC_ISSUE);
    assign w_grp_start = (r_state == c_COMPUTE) && (r_cyc == '0);
    assign w_rcol      = r_cyc[c_NW-1:0];
    assign w_raddr     = c_AW'(int'(r_grp) * N + int'(w_rcol));
    assign w_waddr     = c_AW'(int'(r_grp) * N + int'(r_col));

    always_ff @(posedge clk) begin
        if (r_state == c_LOAD_X && w_s_hs)
            r_x[r_col] <= data_in;
        r_xd <= r_x[w_rcol];
    end

    // r_vld[0] marks valid bank read data, r_vld[s+1] valid product stage s.
    always_ff @(posedge clk) begin
        if (reset)
            r_vld <= '0;
        else
            r_vld <= {r_vld[MAC_STAGES-1:0], w_issue};
    end

    // ---------------- MAC lanes ----------------
    for (genvar k = 0; k < P; k++) begin : g_lane
        logic signed [IN_W-1:0]    r_mem [c_DEPTH];
        logic signed [IN_W-1:0]    r_wd;
        logic signed [2*IN_W-1:0]  w_prod;
        logic signed [OUT_W-1:0]   r_pipe [MAC_STAGES];
        logic signed [OUT_W-1:0]   r_acc;
        logic                      r_ovf;
        logic [OUT_W:0]            w_sum;
        logic                      w_sum_ovf;
        logic signed [OUT_W-1:0]   w_acc_nx;

        // Bank k holds rows k, k+P, k+2P, ... at address group*N + column.
        always_ff @(posedge clk) begin
            if (r_state == c_LOAD_W && w_s_hs && r_lane == c_LW'(k))
                r_mem[w_waddr] <= data_in;
            r_wd <= r_mem[w_raddr];
        end

        // With OUT_W >= 2*IN_W the full product always fits, so sign
        // extension alone is exact and no product clamp can occur.
        assign w_prod = r_wd * r_xd;

        always_ff @(posedge clk) begin
            r_pipe[0] <= OUT_W'(w_prod);
            for (int s = 1; s < MAC_STAGES; s++)
                r_pipe[s] <= r_pipe[s-1];
        end

        // One guard bit detects signed overflow of the accumulate.
        assign w_sum     = {r_acc[OUT_W-1], r_acc}
                         + {r_pipe[MAC_STAGES-1][OUT_W-1], r_pipe[MAC_STAGES-1]};
        assign w_sum_ovf = w_sum[OUT_W] ^ w_sum[OUT_W-1];
        assign w_acc_nx  = !w_sum_ovf    ? w_sum[OUT_W-1:0] :
                           w_sum[OUT_W]  ? {1'b1, {(OUT_W-1){1'b0}}} :
                                           {1'b0, {(OUT_W-1){1'b1}}};

        always_ff @(posedge clk) begin
            if (reset) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (w_grp_start) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (r_vld[MAC_STAGES]) begin
                r_acc <= w_acc_nx;
                if (w_sum_ovf)
                    r_ovf <= 1'b1;
            end
        end

        assign w_acc_all[k] = r_acc;
        assign w_ovf_all[k] = r_ovf;
    end

    // Accumulators hold their final values throughout DRAIN, so they double
    // as the result buffer.
    assign data_out = w_acc_all[r_lane];
    assign overflow = w_ovf_all[r_lane];

endmodule
`default_nettype wire

// File: tb/tb_mvm_stream_par.sv
`default_nettype none
// ============================================================================
// Module   : tb_mvm_stream_par
// Purpose  : Self-checking bench for mvm_stream_par. Directed and random
//            frames are checked against a saturating arithmetic model of
//            y = W*x, including output latency and handshake behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mvm_stream_par;

    localparam int M     = 4;
    localparam int N     = 4;
    localparam int P     = 2;
    localparam int IN_W  = 8;
    localparam int OUT_W = 16;
    localparam int MS    = 2;
    localparam int LAT   = N + MS + 2;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    s_valid = 1'b0;
    logic                    s_ready;
    logic signed [IN_W-1:0]  data_in = '0;
    logic                    m_valid;
    logic                    m_ready = 1'b0;
    logic signed [OUT_W-1:0] data_out;
    logic                    overflow;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     last_hs = 0;
    bit     reuse_active = 1'b0;
    int     w_m [M][N];
    int     x_in [N];
    int     x_cur [N];
    longint exp_y [M];
    bit     exp_o [M];

    mvm_stream_par #(
        .M(M), .N(N), .P(P), .IN_W(IN_W), .OUT_W(OUT_W), .MAC_STAGES(MS)
    ) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in),
        .m_valid(m_valid), .m_ready(m_ready),
        .data_out(data_out), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, expv);
        end
    endtask

    // Row-by-row dot product with saturation applied after every add.
    function automatic void model();
        longint mx = (longint'(1) <<< (OUT_W - 1)) - 1;
        longint mn = -(longint'(1) <<< (OUT_W - 1));
        for (int r = 0; r < M; r++) begin
            longint acc = 0;
            bit     o = 1'b0;
            for (int c = 0; c < N; c++) begin
                acc = acc + longint'(w_m[r][c] * x_cur[c]);
                if (acc > mx) begin acc = mx; o = 1'b1; end
                else if (acc < mn) begin acc = mn; o = 1'b1; end
            end
            exp_y[r] = acc;
            exp_o[r] = o;
        end
    endfunction

    task automatic do_reset();
        reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        reuse_active = 1'b0;
    endtask

    task automatic send_elem(input int v, input bit gaps);
        int t;
        if (gaps) begin
            t = 0;
            while ($urandom_range(0, 1) == 1 && t < 8) begin
                s_valid = 1'b0; @(posedge clk); #1; t++;
            end
        end
        s_valid = 1'b1;
        data_in = IN_W'(v);
        t = 0;
        while (!s_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (!s_ready) chk("s_ready_timeout", s_ready, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        last_hs = cyc;
    endtask

    // mode 0: m_ready always 1; 1: random m_ready; 2: hold 10 cycles on first row
    task automatic collect(input int mode, input int ref_cyc);
        int row = 0, t = 0, gref, hold = 0;
        bit seen = 1'b0, prev_acc = 1'b0, prev_last = 1'b0;
        gref = ref_cyc;
        while (row < M && t < 3000) begin
            if (prev_acc) begin
                if (prev_last) chk("mvalid_drop", m_valid, 0);
                else           chk("mvalid_b2b", m_valid, 1);
                prev_acc = 1'b0;
            end
            if (m_valid && !seen) begin
                seen = 1'b1;
                chk("latency", cyc - gref, LAT);
                chk("s_ready_busy", s_ready, 0);
                if (mode == 2 && row == 0) hold = 10;
            end
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: if (hold > 0) begin m_ready = 1'b0; hold--; end
                         else m_ready = 1'b1;
            endcase
            if (m_valid) begin
                chk("data", data_out, exp_y[row]);
                chk("ovf", overflow, exp_o[row]);
                if (!m_ready) chk("s_ready_hold", s_ready, 0);
            end
            if (m_valid && m_ready) begin
                prev_acc  = 1'b1;
                prev_last = (row % P == P - 1);
                row++;
                if (prev_last) begin seen = 1'b0; gref = cyc + 1; end
            end
            @(posedge clk); #1;
            t++;
        end
        chk("rows_done", row, M);
        chk("idle_s_ready", s_ready, 1);
        chk("idle_m_valid", m_valid, 0);
        m_ready = 1'b0;
    endtask

    task automatic run_frame(input int mode, input bit gaps);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                send_elem(w_m[r][c], gaps);
        if (!reuse_active) begin
            for (int c = 0; c < N; c++) send_elem(x_in[c], gaps);
            x_cur = x_in;
        end
        model();
        collect(mode, last_hs);
`ifdef MVM_VEC_REUSE_EN
        reuse_active = 1'b1;
`endif
    endtask

    task automatic rand_frame();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                w_m[r][c] = int'($urandom_range(0, 255)) - 128;
        for (int c = 0; c < N; c++) x_in[c] = int'($urandom_range(0, 255)) - 128;
    endtask

    initial begin
        do_reset();
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_ovf", overflow, 0);

        // identity
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++) w_m[r][c] = (r == c) ? 1 : 0;
        for (int c = 0; c < N; c++) x_in[c] = c + 1;
        run_frame(0, 1'b0);

        // positive and negative saturation
        do_reset();
        for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) w_m[r][c] = 127;
        for (int c = 0; c < N; c++) x_in[c] = 127;
        run_frame(0, 1'b0);
        do_reset();
        for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) w_m[r][c] = -128;
        run_frame(0, 1'b0);

        // cancelling rows, then sticky flag must not leak into next frame
        do_reset();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++) w_m[r][c] = (c % 2 == 0) ? r : -r;
        for (int c = 0; c < N; c++) x_in[c] = 5;
        run_frame(0, 1'b0);
        for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) w_m[r][c] = 1;
        x_in[0] = 1; x_in[1] = -1; x_in[2] = 2; x_in[3] = -2;
        run_frame(0, 1'b0);

        // backpressure on first row
        rand_frame();
        run_frame(2, 1'b0);

        // random frames with input gaps and random m_ready
        repeat (4) begin
            rand_frame();
            run_frame(1, 1'b1);
        end

        // reset in the middle of loading W
        rand_frame();
        for (int i = 0; i < 7; i++) send_elem(w_m[i / N][i % N], 1'b0);
        do_reset();
        chk("midrst_s_ready", s_ready, 1);
        chk("midrst_m_valid", m_valid, 0);
        rand_frame();
        run_frame(1, 1'b1);
        rand_frame();
        run_frame(0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
